// File: rtl/rdma_tx_arb.sv
// Packet-level round-robin arbiter feeding the RDMA TX stage through one register.
// Define RDMA_TX_ARB_ACK_PRIO_EN to give requester 0 (ACK/NAK) absolute priority.
module rdma_tx_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 64,
   parameter int IPG_CYCLES = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        tx_in_valid,
   output logic [DATA_W-1:0]           tx_in_data,
   output logic                        tx_in_last,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy
);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   ptr, ptr_nxt;
   logic [IW-1:0]   grant, grant_nxt;
   logic [IW-1:0]   pick, idx;
   logic            found;
   logic [3:0]      gap_cnt, gap_nxt;
   logic            acc;
   logic [DATA_W-1:0] sel_data;
   logic            sel_last;

   // Scan starts just after the last round-robin winner.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
`ifdef RDMA_TX_ARB_ACK_PRIO_EN
      if (req_valid[0]) begin
         found = 1'b1;
         pick  = '0;
      end
`endif
   end

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == IW'(i)) begin
            sel_data = req_data[i*DATA_W +: DATA_W];
            sel_last = req_last[i];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      gap_nxt   = gap_cnt;
      req_ready = '0;
      acc       = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               grant_nxt = pick;
               state_nxt = XFER;
`ifdef RDMA_TX_ARB_ACK_PRIO_EN
               if (pick != '0) ptr_nxt = pick;
`else
               ptr_nxt = pick;
`endif
            end
         end
         XFER: begin
            req_ready[grant] = 1'b1;
            acc = req_valid[grant];
            if (acc && sel_last) begin
               if (IPG_CYCLES > 0) begin
                  state_nxt = GAP;
                  gap_nxt   = 4'(IPG_CYCLES - 1);
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt == 4'd0) state_nxt = IDLE;
            else gap_nxt = gap_cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
      // Nothing may be accepted while reset is held.
      if (rst) begin
         req_ready = '0;
         acc       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= IW'(NUM_REQ - 1);
         grant       <= '0;
         gap_cnt     <= '0;
         tx_in_valid <= 1'b0;
         tx_in_data  <= '0;
         tx_in_last  <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         grant       <= grant_nxt;
         gap_cnt     <= gap_nxt;
         tx_in_valid <= acc;
         if (acc) begin
            tx_in_data <= sel_data;
            tx_in_last <= sel_last;
         end
      end
   end

   assign grant_id = grant;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_rdma_tx_arb.sv
// Directed bench for rdma_tx_arb: vector table plus multi-cycle traffic sequences.
// Main instance uses IPG_CYCLES=0, a second instance uses IPG_CYCLES=3.
module tb_rdma_tx_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_last;

   logic [3:0]  rdy_m, rdy_g;
   logic        tv_m, tv_g;
   logic [15:0] td_m, td_g;
   logic        tl_m, tl_g;
   logic [1:0]  gid_m, gid_g;
   logic        busy_m, busy_g;

   rdma_tx_arb #(.NUM_REQ(4), .DATA_W(16), .IPG_CYCLES(0)) dut_m (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(rdy_m), .tx_in_valid(tv_m),
      .tx_in_data(td_m), .tx_in_last(tl_m), .grant_id(gid_m), .busy(busy_m));

   rdma_tx_arb #(.NUM_REQ(4), .DATA_W(16), .IPG_CYCLES(3)) dut_g (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(rdy_g), .tx_in_valid(tv_g),
      .tx_in_data(td_g), .tx_in_last(tl_g), .grant_id(gid_g), .busy(busy_g));

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic [3:0]  l;
      logic [63:0] d;
      logic [3:0]  rdy;
      logic        tv;
      logic [15:0] td;
      logic        tl;
      logic [1:0]  g;
      logic        b;
   } vec_t;

   vec_t tbl[12];

   int n_chk = 0;
   int n_fail = 0;

   int bt[4], pk[4], hold[4], plen[4], maxpk[4];
   int bub_req, bub_len, sel, rdy0_cnt;

   logic        log_v[$];
   logic [15:0] log_d[$];
   logic        log_l[$];
   logic [1:0]  log_g[$];
   int srcs[$], gaps[$], inidle[$];
   int n_ilv;
   int exp_fair[8];
   int exp_mac[4];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bt[i] = 0; pk[i] = 0; hold[i] = 0; plen[i] = 1; maxpk[i] = 0;
      end
      bub_req = -1; bub_len = 0; sel = 0; rdy0_cnt = 0;
      log_v.delete(); log_d.delete(); log_l.delete(); log_g.delete();
   endtask

   task automatic run(input int ncyc);
      logic [3:0]  v, rl, rdy;
      logic [63:0] rd;
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < 4; i++) begin
            v[i]  = (pk[i] < maxpk[i]) && (hold[i] == 0);
            rl[i] = (bt[i] == plen[i] - 1);
            rd[i*16 +: 16] = {4'(i), 4'(pk[i]), 8'(bt[i])};
         end
         req_valid = v;
         req_last  = rl;
         req_data  = rd;
         #1;
         rdy = sel ? rdy_g : rdy_m;
         if (rdy[0]) rdy0_cnt++;
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (hold[i] > 0) hold[i]--;
            else if (v[i] && rdy[i]) begin
               if (i == bub_req && bt[i] == 0 && pk[i] == 0) hold[i] = bub_len;
               if (rl[i]) begin bt[i] = 0; pk[i]++; end
               else bt[i]++;
            end
         end
         log_v.push_back(sel ? tv_g : tv_m);
         log_d.push_back(sel ? td_g : td_m);
         log_l.push_back(sel ? tl_g : tl_m);
         log_g.push_back(sel ? gid_g : gid_m);
      end
   endtask

   task automatic analyze();
      int open, cur, lastend, idle_in, expbeat, src;
      open = 0; cur = -1; lastend = -1; idle_in = 0; expbeat = 0;
      n_ilv = 0;
      srcs.delete(); gaps.delete(); inidle.delete();
      for (int k = 0; k < log_v.size(); k++) begin
         if (log_v[k]) begin
            src = int'(log_d[k][15:12]);
            if (open == 0) begin
               open = 1; cur = src; expbeat = 0; idle_in = 0;
               if (lastend >= 0) gaps.push_back(k - lastend - 1);
            end else if (src != cur) n_ilv++;
            if (int'(log_d[k][7:0]) != expbeat) n_ilv++;
            expbeat++;
            if (log_l[k]) begin
               open = 0;
               srcs.push_back(cur);
               inidle.push_back(idle_in);
               lastend = k;
            end
         end else if (open != 0) begin
            idle_in++;
            if (int'(log_g[k]) != cur) n_ilv++;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0, 4'h4, 4'h0, 64'h0000_0011_0000_0000, 4'h0, 0, 16'h00, 0, 2'd2, 1};
      tbl[1]  = '{0, 4'h4, 4'h0, 64'h0000_0011_0000_0000, 4'h4, 1, 16'h11, 0, 2'd2, 1};
      tbl[2]  = '{0, 4'h4, 4'h0, 64'h0000_0022_0000_0000, 4'h4, 1, 16'h22, 0, 2'd2, 1};
      tbl[3]  = '{0, 4'h4, 4'h4, 64'h0000_0033_0000_0000, 4'h4, 1, 16'h33, 1, 2'd2, 0};
      tbl[4]  = '{0, 4'h0, 4'h0, 64'h0000_0000_0000_0000, 4'h0, 0, 16'h33, 1, 2'd2, 0};
      tbl[5]  = '{0, 4'h8, 4'h0, 64'h00A1_0000_0000_0000, 4'h0, 0, 16'h33, 1, 2'd3, 1};
      tbl[6]  = '{0, 4'h8, 4'h0, 64'h00A1_0000_0000_0000, 4'h8, 1, 16'hA1, 0, 2'd3, 1};
      tbl[7]  = '{1, 4'h8, 4'h0, 64'h00A2_0000_0000_0000, 4'h0, 0, 16'h00, 0, 2'd0, 0};
      tbl[8]  = '{0, 4'h9, 4'h0, 64'h00A3_0000_0000_00B1, 4'h0, 0, 16'h00, 0, 2'd0, 1};
      tbl[9]  = '{0, 4'h9, 4'h1, 64'h00A3_0000_0000_00B1, 4'h1, 1, 16'hB1, 1, 2'd0, 0};
      tbl[10] = '{0, 4'h8, 4'h0, 64'h00A3_0000_0000_0000, 4'h0, 0, 16'hB1, 1, 2'd3, 1};
      tbl[11] = '{0, 4'h8, 4'h8, 64'h00A3_0000_0000_0000, 4'h8, 1, 16'hA3, 1, 2'd3, 0};

`ifdef RDMA_TX_ARB_ACK_PRIO_EN
      exp_fair = '{0, 0, 1, 2, 3, 1, 2, 3};
      exp_mac  = '{0, 0, 0, 0};
`else
      exp_fair = '{0, 1, 2, 3, 0, 1, 2, 3};
      exp_mac  = '{0, 2, 0, 2};
`endif

      rst = 1'b1;
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset ready", rdy_m, 4'h0);
      chk("reset outputs", {tv_m, td_m, tl_m, gid_m, busy_m}, 21'h0);
      rst = 1'b0;

      for (int k = 0; k < 12; k++) begin
         rst       = tbl[k].rst;
         req_valid = tbl[k].v;
         req_last  = tbl[k].l;
         req_data  = tbl[k].d;
         #1;
         chk($sformatf("vec%0d ready", k), rdy_m, tbl[k].rdy);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out", k), {tv_m, td_m, tl_m, gid_m, busy_m},
             {tbl[k].tv, tbl[k].td, tbl[k].tl, tbl[k].g, tbl[k].b});
      end

      // Fairness: four requesters, two 2-beat packets each.
      do_reset();
      for (int i = 0; i < 4; i++) begin plen[i] = 2; maxpk[i] = 2; end
      run(40);
      analyze();
      chk("fair pkts", srcs.size(), 8);
      for (int i = 0; i < srcs.size() && i < 8; i++)
         chk($sformatf("fair order%0d", i), srcs[i], exp_fair[i]);
      for (int i = 0; i < gaps.size(); i++)
         chk($sformatf("fair gap%0d", i), gaps[i], 1);
      chk("fair interleave", n_ilv, 0);

      // Bubble: requester 1 stalls 2 cycles after beat 1, requester 3 waiting.
      do_reset();
      plen[1] = 4; maxpk[1] = 1;
      plen[3] = 2; maxpk[3] = 1;
      bub_req = 1; bub_len = 2;
      run(20);
      analyze();
      chk("bub pkts", srcs.size(), 2);
      if (srcs.size() == 2) begin
         chk("bub first", srcs[0], 1);
         chk("bub second", srcs[1], 3);
         chk("bub idle", inidle[0], 2);
         chk("bub gap", gaps[0], 1);
      end
      chk("bub interleave", n_ilv, 0);

      // Inter-packet gap instance.
      do_reset();
      sel = 1;
      plen[0] = 1; maxpk[0] = 2;
      run(20);
      analyze();
      chk("gap pkts", srcs.size(), 2);
      if (gaps.size() == 1) chk("gap idle", gaps[0], 4);
      else chk("gap count", gaps.size(), 1);
      chk("gap ready0 cycles", rdy0_cnt, 2);

      // Requester 0 vs 2 with 1-beat packets.
      do_reset();
      plen[0] = 1; maxpk[0] = 8;
      plen[2] = 1; maxpk[2] = 8;
      run(12);
      analyze();
      chk("mac pkts ge4", srcs.size() >= 4, 1'b1);
      for (int i = 0; i < srcs.size() && i < 4; i++)
         chk($sformatf("mac grant%0d", i), srcs[i], exp_mac[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
